// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch block.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } redirect_sel_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: priority JumpReg > Jump > BranchTaken > sequential,
// plus the target arithmetic for each redirect kind (all mod 2^32).
// Build option MISALIGN_CHECK_EN: misaligned JR targets divert to EXC_VECTOR
// and raise jr_misaligned; otherwise the low two target bits are dropped.
module next_pc_mux
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic [31:0]   pc_plus4,
  input  logic          branch_taken,
  input  logic          jump,
  input  logic          jump_reg,
  input  logic [31:0]   branch_base,
  input  logic [31:0]   branch_offset_shifted,
  input  logic [25:0]   jump_index,
  input  logic [31:0]   reg_target,
  output redirect_sel_t sel,
  output logic [31:0]   next_pc,
  output logic          jr_misaligned
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign br_target = branch_base + branch_offset_shifted;
  assign j_target  = {branch_base[31:28], jump_index, 2'b00};

`ifdef MISALIGN_CHECK_EN
  assign jr_misaligned = (reg_target[1:0] != 2'b00);
  assign jr_target     = jr_misaligned ? EXC_VECTOR : reg_target;
`else
  logic unused_jr_bits;
  assign unused_jr_bits = ^{reg_target[1:0], EXC_VECTOR};
  assign jr_misaligned  = 1'b0;
  assign jr_target      = {reg_target[31:2], 2'b00};
`endif

  // Highest-priority active redirect wins; no redirect means fall through to PC+4.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus4;
    if (jump_reg) begin
      sel     = SEL_JR;
      next_pc = jr_target;
    end else if (jump) begin
      sel     = SEL_J;
      next_pc = j_target;
    end else if (branch_taken) begin
      sel     = SEL_BR;
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request sequencer.
// A redirect that arrives while a request is still waiting on ImemReady is
// parked in a pending register; the in-flight fetch then completes as a
// squashed wrong-path fetch and PC loads the parked target.
// Build option MISALIGN_CHECK_EN enables the sticky misaligned-JR flag.
//
//   state | meaning
//   BOOT  | one idle cycle after reset
//   REQ   | ImemReq high, ImemAddr held until ImemReady
//   HOLD  | decode stalled, no request, PC frozen
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchBase,
  input  logic [31:0] BranchOffsetShifted,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic        ImemReady,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        MisalignErr
);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc_plus4_q, pc_plus4_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_target_q, pend_target_d;
  logic          misalign_q, misalign_d;

  redirect_sel_t sel;
  logic [31:0]   mux_pc;
  logic          jr_misaligned;
  logic          redirect_now;

  next_pc_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_mux (
    .pc_plus4              (pc_plus4_q),
    .branch_taken          (BranchTaken),
    .jump                  (Jump),
    .jump_reg              (JumpReg),
    .branch_base           (BranchBase),
    .branch_offset_shifted (BranchOffsetShifted),
    .jump_index            (JumpIndex),
    .reg_target            (RegTarget),
    .sel                   (sel),
    .next_pc               (mux_pc),
    .jr_misaligned         (jr_misaligned)
  );

  assign redirect_now = (sel != SEL_SEQ);

  // Next-state, PC update, redirect parking and delivery strobe.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    misalign_d    = misalign_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (ImemReady) begin
          pend_valid_d = 1'b0;
          if (redirect_now) begin
            pc_d = mux_pc;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d          = mux_pc;
            fetch_valid_d = 1'b1;
            if (Stall) state_d = HOLD;
          end
        end else if (redirect_now) begin
          pend_valid_d  = 1'b1;
          pend_target_d = mux_pc;
        end
      end
      HOLD: begin
        if (redirect_now) pc_d = mux_pc;
        if (!Stall) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
    if ((state_q != BOOT) && (sel == SEL_JR) && jr_misaligned) misalign_d = 1'b1;
  end

  assign pc_plus4_d = pc_d + PC_STEP;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_plus4_q    <= RESET_VECTOR + PC_STEP;
      fetch_valid_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      fetch_valid_q <= fetch_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  assign ImemReq     = (state_q == REQ);
  assign ImemAddr    = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4_q;
  assign FetchValid  = fetch_valid_q;
  assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Every accepted (non-squashed) fetch pushes
// the PC value expected while FetchValid is high; a negedge monitor pops and
// compares on each FetchValid strobe.
module tb_pc_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchBase = 32'd0;
  logic [31:0] BranchOffsetShifted = 32'd0;
  logic        Jump = 1'b0;
  logic [25:0] JumpIndex = 26'd0;
  logic        JumpReg = 1'b0;
  logic [31:0] RegTarget = 32'd0;
  logic        ImemReady = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        MisalignErr;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit dut (
    .Clk                 (Clk),
    .Rst_n               (Rst_n),
    .Stall               (Stall),
    .BranchTaken         (BranchTaken),
    .BranchBase          (BranchBase),
    .BranchOffsetShifted (BranchOffsetShifted),
    .Jump                (Jump),
    .JumpIndex           (JumpIndex),
    .JumpReg             (JumpReg),
    .RegTarget           (RegTarget),
    .ImemReady           (ImemReady),
    .ImemReq             (ImemReq),
    .ImemAddr            (ImemAddr),
    .PC                  (PC),
    .PCPlus4             (PCPlus4),
    .FetchValid          (FetchValid),
    .MisalignErr         (MisalignErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each FetchValid must match the oldest expected delivery.
  always @(negedge Clk) begin : mon
    logic [31:0] e;
    if (Rst_n && FetchValid) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_fetch_valid: observed 1 expected 0 (no delivery pending)");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("delivered_pc", PC, e);
        chk("delivered_pcplus4", PCPlus4, e + 32'd4);
      end
    end
  end

  initial begin
    // Reset values.
    @(negedge Clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pcplus4", PCPlus4, 32'h4);
    chk("rst_req", ImemReq, 1'b0);
    chk("rst_fv", FetchValid, 1'b0);
    chk("rst_misalign", MisalignErr, 1'b0);
    Rst_n = 1'b1;

    // BOOT lasts one cycle, then sequential fetch 0,4,8 with ImemReady held.
    @(negedge Clk);
    chk("boot_req", ImemReq, 1'b1);
    chk("seq_addr0", ImemAddr, 32'h0);
    ImemReady = 1'b1;
    exp_q.push_back(32'h4);
    @(negedge Clk);
    chk("seq_addr1", ImemAddr, 32'h4);
    chk("seq_req1", ImemReq, 1'b1);
    exp_q.push_back(32'h8);
    @(negedge Clk);
    chk("seq_addr2", ImemAddr, 32'h8);
    exp_q.push_back(32'hC);
    @(negedge Clk);
    chk("seq_addr3", ImemAddr, 32'hC);

    // Branch while the request is outstanding: parked, fetch squashed.
    ImemReady           = 1'b0;
    BranchTaken         = 1'b1;
    BranchBase          = 32'h0000_0104;
    BranchOffsetShifted = 32'hFFFF_FFF0;
    @(negedge Clk);
    BranchTaken = 1'b0;
    chk("br_addr_stable", ImemAddr, 32'hC);
    ImemReady = 1'b1;
    @(negedge Clk);
    chk("br_addr", ImemAddr, 32'h0000_00F4);
    chk("br_squash_fv", FetchValid, 1'b0);
    chk("br_pcplus4", PCPlus4, 32'h0000_00F8);

    // Jump and branch together: jump wins.
    Jump                = 1'b1;
    BranchTaken         = 1'b1;
    JumpIndex           = 26'h000_0040;
    BranchBase          = 32'h1000_0008;
    BranchOffsetShifted = 32'h0000_0020;
    @(negedge Clk);
    Jump        = 1'b0;
    BranchTaken = 1'b0;
    chk("jmp_addr", ImemAddr, 32'h1000_0100);
    chk("jmp_squash_fv", FetchValid, 1'b0);
    ImemReady = 1'b0;

    // Memory wait for 3 cycles: address held stable.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("wait_addr", ImemAddr, 32'h1000_0100);
      chk("wait_req", ImemReq, 1'b1);
    end
    ImemReady = 1'b1;
    Stall     = 1'b1;
    exp_q.push_back(32'h1000_0104);
    @(negedge Clk);
    ImemReady = 1'b0;
    chk("hold_req1", ImemReq, 1'b0);
    chk("hold_pc1", PC, 32'h1000_0104);
    @(negedge Clk);
    chk("hold_req2", ImemReq, 1'b0);
    chk("hold_pc2", PC, 32'h1000_0104);
    chk("hold_fv2", FetchValid, 1'b0);
    Stall = 1'b0;
    @(negedge Clk);
    chk("resume_req", ImemReq, 1'b1);
    chk("resume_addr", ImemAddr, 32'h1000_0104);

    // Jump-register to a misaligned target.
    JumpReg   = 1'b1;
    RegTarget = 32'h0000_2002;
    ImemReady = 1'b1;
    @(negedge Clk);
    JumpReg   = 1'b0;
    ImemReady = 1'b0;
`ifdef MISALIGN_CHECK_EN
    chk("jr_addr", ImemAddr, 32'h0000_0080);
    chk("jr_misalign", MisalignErr, 1'b1);
`else
    chk("jr_addr", ImemAddr, 32'h0000_2000);
    chk("jr_misalign", MisalignErr, 1'b0);
`endif
    chk("jr_squash_fv", FetchValid, 1'b0);
    @(negedge Clk);
`ifdef MISALIGN_CHECK_EN
    chk("jr_misalign_sticky", MisalignErr, 1'b1);
`else
    chk("jr_misalign_sticky", MisalignErr, 1'b0);
`endif

    // PC wrap at the top of the address space.
    JumpReg   = 1'b1;
    RegTarget = 32'hFFFF_FFFC;
    ImemReady = 1'b1;
    @(negedge Clk);
    JumpReg = 1'b0;
    chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4, 32'h0);
    exp_q.push_back(32'h0);
    @(negedge Clk);
    chk("wrap_addr_next", ImemAddr, 32'h0);

    // Reach PC=0x40, park a branch, then reset mid-request.
    Jump       = 1'b1;
    JumpIndex  = 26'h000_0010;
    BranchBase = 32'h0;
    @(negedge Clk);
    Jump = 1'b0;
    chk("pre_rst_addr", ImemAddr, 32'h0000_0040);
    ImemReady           = 1'b0;
    BranchTaken         = 1'b1;
    BranchBase          = 32'h0000_0200;
    BranchOffsetShifted = 32'h0;
    @(negedge Clk);
    BranchTaken = 1'b0;
    chk("pre_rst_req", ImemReq, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_req", ImemReq, 1'b0);
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_pcplus4", PCPlus4, 32'h4);
    chk("async_rst_misalign", MisalignErr, 1'b0);
    @(negedge Clk);
    Rst_n     = 1'b1;
    ImemReady = 1'b1;
    @(negedge Clk);
    chk("post_rst_req", ImemReq, 1'b1);
    chk("post_rst_addr", ImemAddr, 32'h0);
    exp_q.push_back(32'h4);
    @(negedge Clk);
    chk("post_rst_addr_next", ImemAddr, 32'h4);
    ImemReady = 1'b0;
    @(negedge Clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
